// File: rtl/mspu_sched_pkg.sv
// Shared types and helpers for the core dispatch scheduler.
package mspu_sched_pkg;

    typedef enum logic [0:0] {
        S_SEARCH,
        S_OFFER
    } sched_state_t;

    // Index width that stays at least one bit even for a single core.
    function automatic int unsigned core_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin find-first: lowest request index at or after ptr, wrapping.
module rr_pick #(
    parameter int unsigned N = 4,
    parameter int unsigned W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic         found,
    output logic [W-1:0] idx
);

    logic [W-1:0] cand;

    // Walk the candidates starting at ptr; N is a power of two, so W-bit wrap is modulo N.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int unsigned k = 0; k < N; k++) begin
            cand = ptr + W'(k);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/core_dispatch_scheduler.sv
// Tracks busy/idle cores, offers one idle core at a time to the parser, frees cores on
// done or watchdog expiry.
module core_dispatch_scheduler
    import mspu_sched_pkg::*;
#(
    parameter int unsigned  CORES   = 4,
    parameter int unsigned  TIMEOUT = 0,
    parameter int unsigned  CW      = 32,
    localparam int unsigned CORE_W  = core_w(CORES)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [CORES-1:0]  core_enable,
    input  logic [CORES-1:0]  core_done,
    input  logic              target_core_valid,
    input  logic [CORE_W-1:0] target_core,
    output logic              core_valid,
    output logic [CORE_W-1:0] core_id,
    output logic [CORES-1:0]  busy_mask,
    output logic [CORE_W:0]   idle_count,
    output logic [CW-1:0]     dispatch_count,
    output logic              timeout_pulse,
    output logic [CORE_W-1:0] timeout_core,
    output logic              err_pulse
);

    localparam int unsigned WD_LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    sched_state_t      state_q, state_d;
    logic              started_q;
    logic [CORE_W-1:0] ptr_q, ptr_d;
    logic [CORE_W-1:0] id_q, id_d;
    logic [CORE_W-1:0] to_core_q, to_core_d;
    logic [CORES-1:0]  busy_q, busy_d;
    logic [CORES-1:0]  wd_hit, wd_free, done_ok, avail;
    logic [CORE_W:0]   idle_q, idle_d;
    logic [CW-1:0]     disp_q, disp_d;
    logic              err_q, err_d;
    logic              to_pulse_q, to_pulse_d;
    logic              accept, mismatch, pick_found;
    logic [CORE_W-1:0] pick_idx;

    // The first search waits one cycle after reset release.
    assign avail = core_enable & ~busy_q & {CORES{started_q}};

    rr_pick #(
        .N (CORES),
        .W (CORE_W)
    ) u_rr_pick (
        .req   (avail),
        .ptr   (ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Offer FSM: search for an idle core, then hold the offer until the parser takes it.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        id_d     = id_q;
        disp_d   = disp_q;
        accept   = 1'b0;
        mismatch = 1'b0;
        unique case (state_q)
            S_SEARCH: begin
                if (pick_found) begin
                    id_d    = pick_idx;
                    state_d = S_OFFER;
                end
            end
            S_OFFER: begin
                if (target_core_valid) begin
                    if (target_core == id_q) begin
                        accept  = 1'b1;
                        ptr_d   = id_q + CORE_W'(1);
                        disp_d  = disp_q + CW'(1);
                        state_d = S_SEARCH;
                    end else begin
                        mismatch = 1'b1;
                    end
                end
            end
            default: state_d = S_SEARCH;
        endcase
    end

    // Busy flags, watchdog release (lowest index first, done wins), errors and idle count.
    always_comb begin
        done_ok    = core_done & busy_q;
        wd_free    = '0;
        to_pulse_d = 1'b0;
        to_core_d  = '0;
        for (int unsigned i = 0; i < CORES; i++) begin
            if (!to_pulse_d && wd_hit[i] && !core_done[i]) begin
                to_pulse_d = 1'b1;
                to_core_d  = CORE_W'(i);
                wd_free[i] = 1'b1;
            end
        end
        busy_d = busy_q & ~done_ok & ~wd_free;
        if (accept) begin
            busy_d[id_q] = 1'b1;
        end
        err_d  = (|(core_done & ~busy_q)) | mismatch;
        idle_d = '0;
        for (int unsigned i = 0; i < CORES; i++) begin
            idle_d = idle_d + {{CORE_W{1'b0}}, core_enable[i] & ~busy_q[i]};
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_SEARCH;
            started_q  <= 1'b0;
            ptr_q      <= '0;
            id_q       <= '0;
            busy_q     <= '0;
            idle_q     <= '0;
            disp_q     <= '0;
            err_q      <= 1'b0;
            to_pulse_q <= 1'b0;
            to_core_q  <= '0;
        end else begin
            state_q    <= state_d;
            started_q  <= 1'b1;
            ptr_q      <= ptr_d;
            id_q       <= id_d;
            busy_q     <= busy_d;
            idle_q     <= idle_d;
            disp_q     <= disp_d;
            err_q      <= err_d;
            to_pulse_q <= to_pulse_d;
            to_core_q  <= to_core_d;
        end
    end

    if (TIMEOUT > 0) begin : g_wd
        localparam logic [CW-1:0] WD_LAST = CW'(WD_LAST_I);
        for (genvar i = 0; i < CORES; i++) begin : g_core
            logic [CW-1:0] wd_q;
            assign wd_hit[i] = busy_q[i] && (wd_q == WD_LAST);
            // Count while busy; park at the limit until this core's expiry is reported.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    wd_q <= '0;
                end else if (accept && (id_q == CORE_W'(i))) begin
                    wd_q <= '0;
                end else if (!busy_q[i] || core_done[i] || wd_free[i]) begin
                    wd_q <= '0;
                end else if (wd_q != WD_LAST) begin
                    wd_q <= wd_q + CW'(1);
                end
            end
        end
    end else begin : g_no_wd
        assign wd_hit = '0;
    end

    assign core_valid     = (state_q == S_OFFER);
    assign core_id        = id_q;
    assign busy_mask      = busy_q;
    assign idle_count     = idle_q;
    assign dispatch_count = disp_q;
    assign timeout_pulse  = to_pulse_q;
    assign timeout_core   = to_core_q;
    assign err_pulse      = err_q;

endmodule
